// File: rtl/mem_test_fail_log.sv
// mem_test_fail_log: failure logger for the March-style RAM tester.
// Each failing read seen during a run is counted, with saturation, and its details
// (step, sub-phase, address, expected, actual) are pushed into a first-word-fall-through
// FIFO. A host drains the FIFO over a valid/ready port.
// Optional feature: define DROP_DUP_EN to suppress pushing a failure whose {addr,step}
// matches the last entry written during the current run (it is still counted).
module mem_test_fail_log #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    fail_valid,
    input  logic [AW-1:0]           fail_addr,
    input  logic [2:0]              fail_step,
    input  logic [1:0]              fail_phase,
    input  logic [DW-1:0]           fail_exp,
    input  logic [DW-1:0]           fail_act,
    input  logic                    test_fin,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [13+AW+2*DW-8-1:0] rd_data,
    output logic [$clog2(DEPTH):0]  fill,
    output logic [CW-1:0]           err_count,
    output logic                    overflow,
    output logic                    busy,
    output logic                    done,
    output logic                    pass
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = 13 + AW + 2 * DW - 8;
    localparam logic [PW:0] FULL_FILL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOG   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [EW-1:0] mem [DEPTH];
    logic [PW:0]   wr_cnt;
    logic [PW:0]   rd_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          fail_req;
    logic          is_dup;
    logic          push;
    logic          pop;
    logic          drop;
    logic [EW-1:0] entry;

    // Pointers are the low bits of free-running counters; the counter difference is the fill.
    assign wr_ptr = wr_cnt[PW-1:0];
    assign rd_ptr = rd_cnt[PW-1:0];
    assign fill   = wr_cnt - rd_cnt;
    assign full   = (fill == FULL_FILL);

    assign rd_valid = (fill != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    assign entry = {fail_step, fail_phase, fail_addr, fail_exp, fail_act};

    // A restart discards anything arriving in the same cycle, so start masks the request.
    assign fail_req = (state == LOG) && fail_valid && !start;
    assign pop      = rd_valid && rd_ready && !start;
    assign push     = fail_req && !is_dup && (!full || pop);
    assign drop     = fail_req && !is_dup && full && !pop;

`ifdef DROP_DUP_EN
    logic [AW-1:0] last_addr;
    logic [2:0]    last_step;
    logic          last_valid;

    assign is_dup = last_valid && (last_addr == fail_addr) && (last_step == fail_step);

    // Remember the key of the most recently written entry of this run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_addr  <= '0;
            last_step  <= '0;
            last_valid <= 1'b0;
        end else if (start) begin
            last_addr  <= '0;
            last_step  <= '0;
            last_valid <= 1'b0;
        end else if (push) begin
            last_addr  <= fail_addr;
            last_step  <= fail_step;
            last_valid <= 1'b1;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    // FIFO storage; contents are only visible through rd_data while rd_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry;
        end
    end

    // FIFO occupancy counters, cleared at every new run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (start) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (pop) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Saturating error count and sticky overflow flag for the current run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
            overflow  <= 1'b0;
        end else if (start) begin
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (fail_req && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Run-control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOG;
                end
            end
            LOG: begin
                busy = 1'b1;
                if (start) begin
                    state_next = LOG;
                end else if (test_fin) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (start) begin
                    state_next = LOG;
                end else if (fill == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                pass = (err_count == '0);
                if (start) begin
                    state_next = LOG;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_test_fail_log.sv
// tb_mem_test_fail_log: directed bench for mem_test_fail_log at default parameters.
// Expectations for the duplicate-drop case follow the DROP_DUP_EN macro.
module tb_mem_test_fail_log;

    logic        clk;
    logic        reset;
    logic        start;
    logic        fail_valid;
    logic [7:0]  fail_addr;
    logic [2:0]  fail_step;
    logic [1:0]  fail_phase;
    logic [7:0]  fail_exp;
    logic [7:0]  fail_act;
    logic        test_fin;
    logic        rd_valid;
    logic        rd_ready;
    logic [28:0] rd_data;
    logic [3:0]  fill;
    logic [15:0] err_count;
    logic        overflow;
    logic        busy;
    logic        done;
    logic        pass;

    int checks   = 0;
    int failures = 0;

    mem_test_fail_log dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fail_valid (fail_valid),
        .fail_addr  (fail_addr),
        .fail_step  (fail_step),
        .fail_phase (fail_phase),
        .fail_exp   (fail_exp),
        .fail_act   (fail_act),
        .test_fin   (test_fin),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .fill       (fill),
        .err_count  (err_count),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done),
        .pass       (pass)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [28:0] mk(input logic [2:0] s, input logic [1:0] p,
                                       input logic [7:0] a, input logic [7:0] e,
                                       input logic [7:0] r);
        return {s, p, a, e, r};
    endfunction

    // Directed sequence covering reset, normal logging, overflow, full push+pop, async reset, duplicates.
    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        fail_valid = 1'b0;
        fail_addr  = '0;
        fail_step  = '0;
        fail_phase = '0;
        fail_exp   = '0;
        fail_act   = '0;
        test_fin   = 1'b0;
        rd_ready   = 1'b0;

        tick();
        tick();
        check("rst_rd_valid", rd_valid, 0);
        check("rst_fill", fill, 0);
        check("rst_err", err_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b1;
        tick();

        // T1: clean run
        start = 1'b1;
        tick();
        start    = 1'b0;
        test_fin = 1'b1;
        check("t1_busy_log", busy, 1);
        tick();
        test_fin = 1'b0;
        check("t1_busy_drain", busy, 1);
        check("t1_not_done", done, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_err", err_count, 0);
        check("t1_rd_valid", rd_valid, 0);

        // T2: three failures drained in order
        start = 1'b1;
        tick();
        start      = 1'b0;
        fail_step  = 3'd1;
        fail_phase = 2'd0;
        fail_exp   = 8'h55;
        fail_act   = 8'h54;
        for (int i = 0; i < 3; i++) begin
            fail_valid = 1'b1;
            fail_addr  = 8'h10 + 8'(i);
            tick();
        end
        fail_valid = 1'b0;
        check("t2_fill", fill, 3);
        check("t2_err", err_count, 3);
        check("t2_rd_valid", rd_valid, 1);
        test_fin = 1'b1;
        tick();
        test_fin = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_entry", rd_data, mk(3'd1, 2'd0, 8'h10 + 8'(i), 8'h55, 8'h54));
            tick();
        end
        check("t2_empty", fill, 0);
        check("t2_busy", busy, 1);
        tick();
        check("t2_done", done, 1);
        check("t2_pass", pass, 0);
        check("t2_err_final", err_count, 3);
        rd_ready = 1'b0;

        // T3: ten failures into an 8-deep FIFO with no consumer
        start = 1'b1;
        tick();
        start      = 1'b0;
        fail_step  = 3'd2;
        fail_phase = 2'd1;
        fail_exp   = 8'hAA;
        fail_act   = 8'hAB;
        for (int i = 0; i < 10; i++) begin
            fail_valid = 1'b1;
            fail_addr  = 8'(i);
            tick();
        end
        fail_valid = 1'b0;
        check("t3_fill", fill, 8);
        check("t3_ovf", overflow, 1);
        check("t3_err", err_count, 10);
        test_fin = 1'b1;
        tick();
        test_fin = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t3_entry", rd_data, mk(3'd2, 2'd1, 8'(i), 8'hAA, 8'hAB));
            tick();
        end
        check("t3_rd_data_empty", rd_data, 0);
        tick();
        check("t3_done", done, 1);
        check("t3_ovf_sticky", overflow, 1);
        rd_ready = 1'b0;

        // T4: full FIFO with simultaneous push and pop
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_ovf_cleared", overflow, 0);
        check("t4_err_cleared", err_count, 0);
        for (int i = 0; i < 8; i++) begin
            fail_valid = 1'b1;
            fail_addr  = 8'h40 + 8'(i);
            tick();
        end
        check("t4_full", fill, 8);
        fail_addr = 8'h48;
        rd_ready  = 1'b1;
        tick();
        fail_valid = 1'b0;
        rd_ready   = 1'b0;
        check("t4_fill_held", fill, 8);
        check("t4_no_ovf", overflow, 0);
        check("t4_err", err_count, 9);
        test_fin = 1'b1;
        tick();
        test_fin = 1'b0;
        rd_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("t4_entry", rd_data, mk(3'd2, 2'd1, 8'h40 + 8'(i), 8'hAA, 8'hAB));
            tick();
        end
        tick();
        check("t4_done", done, 1);
        rd_ready = 1'b0;

        // T5: asynchronous reset while draining
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fail_valid = 1'b1;
            fail_addr  = 8'h30 + 8'(i);
            tick();
        end
        fail_valid = 1'b0;
        test_fin   = 1'b1;
        tick();
        test_fin = 1'b0;
        check("t5_drain_busy", busy, 1);
        check("t5_drain_fill", fill, 3);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_fill", fill, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_rd_valid", rd_valid, 0);
        check("t5_async_err", err_count, 0);
        tick();
        reset = 1'b1;
        fail_valid = 1'b1;
        fail_addr  = 8'h01;
        tick();
        fail_valid = 1'b0;
        check("t5_idle_busy", busy, 0);
        check("t5_idle_done", done, 0);
        check("t5_idle_err", err_count, 0);
        check("t5_idle_fill", fill, 0);

        // T6: back-to-back duplicate failures
        start = 1'b1;
        tick();
        start     = 1'b0;
        fail_step = 3'd3;
        fail_addr = 8'h20;
        fail_valid = 1'b1;
        tick();
        tick();
        fail_valid = 1'b0;
        check("t6_err", err_count, 2);
`ifdef DROP_DUP_EN
        check("t6_fill", fill, 1);
`else
        check("t6_fill", fill, 2);
`endif

        // T7: restart in the same cycle as a failure clears and discards it
        start      = 1'b1;
        fail_valid = 1'b1;
        fail_addr  = 8'h77;
        tick();
        start      = 1'b0;
        fail_valid = 1'b0;
        check("t7_err", err_count, 0);
        check("t7_fill", fill, 0);
        check("t7_busy", busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
